// File: rtl/fec_pkg.sv
// fec_pkg: shared types and encodings for fetch_exec_ctrl (LDR/STR states exist only with FEC_LDST_EN)
package fec_pkg;
  localparam bit LDST_EN =
`ifdef FEC_LDST_EN
    1'b1;
`else
    1'b0;
`endif
  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPDATE_PC,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_CALC,
    S_WRITE_REG,
    S_HALT
`ifdef FEC_LDST_EN
    ,
    S_CALC_ADDR,
    S_LOAD_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_GET_B_RD,
    S_PASS_B,
    S_MEM_WR
`endif
  } state_t;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;
  localparam logic [1:0] VSEL_MDATA  = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_PC     = 2'b10;
  localparam logic [1:0] VSEL_C      = 2'b11;
  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctrl_t;
  // MOV reg and MVN pass B through the ALU with A forced to zero
  function automatic logic a_zero_op(input logic [2:0] opc, input logic [1:0] o);
    return (opc == OPC_MOV && o == OP_MOV_REG) || (opc == OPC_ALU && o == OP_MVN);
  endfunction
endpackage

// File: rtl/fec_out_decode.sv
// fec_out_decode: state to datapath control word (FEC_LDST_EN adds load/store states)
module fec_out_decode
  import fec_pkg::*;
(
  input  state_t state_i,
  input  logic   a_zero_i,
  input  logic   cmp_i,
  output ctrl_t  ctrl_o
);
  // Every state starts from an all-idle word; without load/store the address always comes from PC
  always_comb begin
    ctrl_o = '0;
    ctrl_o.addr_sel = !LDST_EN;
    case (state_i)
      S_RST: begin
        ctrl_o.reset_pc = 1'b1;
        ctrl_o.load_pc = 1'b1;
      end
      S_IF1: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.mem_cmd = MEM_READ;
      end
      S_IF2: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.mem_cmd = MEM_READ;
        ctrl_o.load_ir = 1'b1;
      end
      S_UPDATE_PC: ctrl_o.load_pc = 1'b1;
      S_WRITE_IMM: begin
        ctrl_o.nsel = NSEL_RN;
        ctrl_o.vsel = VSEL_SXIMM8;
        ctrl_o.write = 1'b1;
      end
      S_GET_A: begin
        ctrl_o.nsel = NSEL_RN;
        ctrl_o.loada = 1'b1;
      end
      S_GET_B: begin
        ctrl_o.nsel = NSEL_RM;
        ctrl_o.loadb = 1'b1;
      end
      S_CALC: begin
        ctrl_o.asel = a_zero_i;
        ctrl_o.loadc = !cmp_i;
        ctrl_o.loads = cmp_i;
      end
      S_WRITE_REG: begin
        ctrl_o.nsel = NSEL_RD;
        ctrl_o.vsel = VSEL_C;
        ctrl_o.write = 1'b1;
      end
`ifdef FEC_LDST_EN
      S_CALC_ADDR: begin
        ctrl_o.bsel = 1'b1;
        ctrl_o.loadc = 1'b1;
      end
      S_LOAD_ADDR: ctrl_o.load_addr = 1'b1;
      S_MEM_RD: ctrl_o.mem_cmd = MEM_READ;
      S_WB_MEM: begin
        ctrl_o.mem_cmd = MEM_READ;
        ctrl_o.nsel = NSEL_RD;
        ctrl_o.vsel = VSEL_MDATA;
        ctrl_o.write = 1'b1;
      end
      S_GET_B_RD: begin
        ctrl_o.nsel = NSEL_RD;
        ctrl_o.loadb = 1'b1;
      end
      S_PASS_B: begin
        ctrl_o.asel = 1'b1;
        ctrl_o.loadc = 1'b1;
      end
      S_MEM_WR: ctrl_o.mem_cmd = MEM_WRITE;
`endif
      S_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl: multi-cycle fetch/decode/execute sequencer; FEC_LDST_EN enables LDR/STR
module fetch_exec_ctrl
  import fec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted
);
  state_t state_q, state_d;
  logic a_zero_q, a_zero_d, cmp_q, cmp_d;
  ctrl_t ctrl;
  // Next state; CALC's flavour is latched at DECODE so outputs depend on state registers only
  always_comb begin
    state_d = state_q;
    a_zero_d = a_zero_q;
    cmp_d = cmp_q;
    case (state_q)
      S_RST: state_d = S_IF1;
      S_IF1: state_d = S_IF2;
      S_IF2: state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE: begin
        a_zero_d = a_zero_op(opcode, op);
        cmp_d = opcode == OPC_ALU && op == OP_CMP;
        case (opcode)
          OPC_MOV: state_d = op == OP_MOV_IMM ? S_WRITE_IMM : op == OP_MOV_REG ? S_GET_B : S_IF1;
          OPC_ALU: state_d = op == OP_MVN ? S_GET_B : S_GET_A;
`ifdef FEC_LDST_EN
          OPC_LDR, OPC_STR: state_d = S_GET_A;
`endif
          OPC_HALT: state_d = S_HALT;
          default: state_d = S_IF1;
        endcase
      end
`ifdef FEC_LDST_EN
      S_GET_A: state_d = opcode == OPC_ALU ? S_GET_B : S_CALC_ADDR;
      S_CALC_ADDR: state_d = S_LOAD_ADDR;
      S_LOAD_ADDR: state_d = opcode == OPC_LDR ? S_MEM_RD : S_GET_B_RD;
      S_MEM_RD: state_d = S_WB_MEM;
      S_WB_MEM: state_d = S_IF1;
      S_GET_B_RD: state_d = S_PASS_B;
      S_PASS_B: state_d = S_MEM_WR;
      S_MEM_WR: state_d = S_IF1;
`else
      S_GET_A: state_d = S_GET_B;
`endif
      S_GET_B: state_d = S_CALC;
      S_CALC: state_d = cmp_q ? S_IF1 : S_WRITE_REG;
      S_WRITE_IMM, S_WRITE_REG: state_d = S_IF1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end
  // State register; reset wins in every state, including mid-memory-write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      a_zero_q <= 1'b0;
      cmp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_zero_q <= a_zero_d;
      cmp_q <= cmp_d;
    end
  end
  fec_out_decode u_dec (
    .state_i (state_q),
    .a_zero_i(a_zero_q),
    .cmp_i   (cmp_q),
    .ctrl_o  (ctrl)
  );
  assign nsel = ctrl.nsel;
  assign vsel = ctrl.vsel;
  assign write = ctrl.write;
  assign loada = ctrl.loada;
  assign loadb = ctrl.loadb;
  assign loadc = ctrl.loadc;
  assign loads = ctrl.loads;
  assign asel = ctrl.asel;
  assign bsel = ctrl.bsel;
  assign load_ir = ctrl.load_ir;
  assign load_pc = ctrl.load_pc;
  assign reset_pc = ctrl.reset_pc;
  assign load_addr = ctrl.load_addr;
  assign addr_sel = ctrl.addr_sel;
  assign mem_cmd = ctrl.mem_cmd;
  assign halted = ctrl.halted;
endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// tb_fetch_exec_ctrl: table-driven per-instruction pulse counts plus reset/halt sequences
module tb_fetch_exec_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic write, loada, loadb, loadc, loads, asel, bsel;
  logic load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;
  logic [1:0] mem_cmd;
  int errs = 0;
  int checks = 0;
`ifdef FEC_LDST_EN
  localparam int RST_ADDR_SEL = 0;
`else
  localparam int RST_ADDR_SEL = 1;
`endif
  typedef struct {
    logic [2:0] opc;
    logic [1:0] op;
    int cyc, wr, wn, lda, ldb, ldc, lds, asl, bsl, rd, mwr, ladr;
  } vec_t;
  vec_t tab[$];
  fetch_exec_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
    .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int in_if1();
    return (addr_sel && mem_cmd == 2'b01 && !load_ir) ? 1 : 0;
  endfunction
  task automatic chk_rst(input string tag);
    chk({tag, "_reset_pc"}, int'(reset_pc), 1);
    chk({tag, "_load_pc"}, int'(load_pc), 1);
    chk({tag, "_addr_sel"}, int'(addr_sel), RST_ADDR_SEL);
    chk({tag, "_others"}, int'({nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                                load_ir, load_addr, mem_cmd, halted}), 0);
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, wr = 0, wn = 0, lda = 0, ldb = 0, ldc = 0, lds = 0, asl = 0, bsl = 0;
    int rd = 0, mwr = 0, ladr = 0, lir = 0, lpc = 0, clash = 0;
    string t;
    t = $sformatf("v%0d", idx);
    opcode = v.opc;
    op = v.op;
    do begin
      cyc++;
      wr += int'(write);
      if (write) wn = int'(nsel);
      lda += int'(loada);
      ldb += int'(loadb);
      ldc += int'(loadc);
      lds += int'(loads);
      asl += int'(asel);
      bsl += int'(bsel);
      rd += (mem_cmd == 2'b01) ? 1 : 0;
      mwr += (mem_cmd == 2'b10) ? 1 : 0;
      ladr += int'(load_addr);
      lir += int'(load_ir);
      lpc += int'(load_pc);
      if (write && mem_cmd == 2'b10) clash++;
      step();
    end while (in_if1() == 0 && cyc < 40);
    chk({t, "_cycles"}, cyc, v.cyc);
    chk({t, "_write"}, wr, v.wr);
    chk({t, "_wr_nsel"}, wn, v.wn);
    chk({t, "_loada"}, lda, v.lda);
    chk({t, "_loadb"}, ldb, v.ldb);
    chk({t, "_loadc"}, ldc, v.ldc);
    chk({t, "_loads"}, lds, v.lds);
    chk({t, "_asel"}, asl, v.asl);
    chk({t, "_bsel"}, bsl, v.bsl);
    chk({t, "_mem_read"}, rd, v.rd);
    chk({t, "_mem_write"}, mwr, v.mwr);
    chk({t, "_load_addr"}, ladr, v.ladr);
    chk({t, "_load_ir"}, lir, 1);
    chk({t, "_load_pc"}, lpc, 1);
    chk({t, "_wr_clash"}, clash, 0);
  endtask
  initial begin
    int n, hcnt, lp, rdc;
    //                  opc     op    cyc wr wn lda ldb ldc lds asl bsl rd mwr ladr
    tab.push_back('{3'b110, 2'b10, 5, 1, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0}); // MOV R0,#7
    tab.push_back('{3'b110, 2'b10, 5, 1, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0}); // MOV R1,#2
    tab.push_back('{3'b101, 2'b00, 8, 1, 2, 1, 1, 1, 0, 0, 0, 2, 0, 0}); // ADD
    tab.push_back('{3'b101, 2'b01, 7, 0, 0, 1, 1, 0, 1, 0, 0, 2, 0, 0}); // CMP
    tab.push_back('{3'b101, 2'b11, 7, 1, 2, 0, 1, 1, 0, 1, 0, 2, 0, 0}); // MVN
    tab.push_back('{3'b101, 2'b10, 8, 1, 2, 1, 1, 1, 0, 0, 0, 2, 0, 0}); // AND
    tab.push_back('{3'b110, 2'b00, 7, 1, 2, 0, 1, 1, 0, 1, 0, 2, 0, 0}); // MOV reg
    tab.push_back('{3'b110, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0}); // bad MOV op
    tab.push_back('{3'b000, 2'b00, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0}); // NOP
    tab.push_back('{3'b010, 2'b11, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0}); // NOP
`ifdef FEC_LDST_EN
    tab.push_back('{3'b100, 2'b00, 10, 0, 0, 1, 1, 2, 0, 1, 1, 2, 1, 1}); // STR
    tab.push_back('{3'b011, 2'b00, 9, 1, 2, 1, 0, 1, 0, 0, 1, 4, 0, 1});  // LDR
`else
    tab.push_back('{3'b100, 2'b00, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0}); // STR as NOP
    tab.push_back('{3'b011, 2'b00, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0}); // LDR as NOP
`endif
    reset = 1'b1;
    opcode = 3'b000;
    op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_rst($sformatf("rst_hold%0d", i));
    end
    reset = 1'b0;
    step();
    chk("first_if1", in_if1(), 1);
    step();
    chk("first_if2_load_ir", int'(load_ir), 1);
    opcode = 3'b000;
    step();
    step();
    step();
    chk("nop_back_to_if1", in_if1(), 1);
    foreach (tab[i]) run_vec(i, tab[i]);
`ifdef FEC_LDST_EN
    opcode = 3'b100;
    op = 2'b00;
    n = 0;
    while (mem_cmd != 2'b10 && n < 20) begin
      step();
      n++;
    end
    chk("str_reached_mem_wr", int'(mem_cmd), 2);
`else
    opcode = 3'b101;
    op = 2'b00;
    for (int i = 0; i < 5; i++) step();
    chk("add_in_get_b", int'(loadb), 1);
`endif
    reset = 1'b1;
    step();
    chk_rst("mid_rst");
    reset = 1'b0;
    step();
    chk("mid_rst_if1", in_if1(), 1);
    opcode = 3'b111;
    op = 2'b00;
    for (int i = 0; i < 4; i++) step();
    hcnt = 0;
    lp = 0;
    rdc = 0;
    for (int i = 0; i < 20; i++) begin
      hcnt += int'(halted);
      lp += int'(load_pc);
      rdc += (mem_cmd != 2'b00) ? 1 : 0;
      if (i == 10) opcode = 3'b110;
      step();
    end
    chk("halt_cycles", hcnt, 20);
    chk("halt_load_pc", lp, 0);
    chk("halt_mem", rdc, 0);
    reset = 1'b1;
    step();
    chk_rst("halt_rst");
    chk("halt_cleared", int'(halted), 0);
    reset = 1'b0;
    step();
    chk("halt_rst_if1", in_if1(), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
